// File: rtl/adsr_env.sv
// ADSR envelope generator driving the VCA cv word.
// Gate edges steer the stage machine; per-stage arithmetic runs on prescaler ticks.
module adsr_env #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1,
  parameter int PRE_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack_rate,
  input  logic [WIDTH-1:0] decay_rate,
  input  logic [WIDTH-1:0] sustain_level,
  input  logic [WIDTH-1:0] release_rate,
  output logic [WIDTH-1:0] env_out,
  output logic [2:0]       state_out,
  output logic             active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ENV_MAX  = '1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] env_q, env_d;
  logic             active_q, active_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick;

  logic [WIDTH:0]   attack_sum;
  logic             attack_full;
  logic [WIDTH:0]   decay_floor;
  logic             decay_done;
  logic             release_done;
  logic             gate_on;
  logic             gate_off;

  // Free-running prescaler; tick marks the last clock of each period.
  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
  end

  // Compares are done one bit wider so neither the add nor the subtract can wrap.
  always_comb begin
    attack_sum   = {1'b0, env_q} + {1'b0, attack_rate};
    attack_full  = (attack_sum >= {1'b0, ENV_MAX});
    decay_floor  = {1'b0, sustain_level} + {1'b0, decay_rate};
    decay_done   = ({1'b0, env_q} <= decay_floor);
    release_done = (env_q <= release_rate);
  end

  always_comb begin
    gate_on  = gate && ((state_q == S_IDLE) || (state_q == S_RELEASE));
    gate_off = !gate && ((state_q == S_ATTACK) || (state_q == S_DECAY) ||
                         (state_q == S_SUSTAIN));
  end

  // Gate edges win over ticks and leave env where it is (retrigger starts from env).
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (gate_on) begin
      state_d = S_ATTACK;
    end else if (gate_off) begin
      state_d = S_RELEASE;
    end else if (tick) begin
      unique case (state_q)
        S_ATTACK: begin
          if (attack_full) begin
            env_d   = ENV_MAX;
            state_d = S_DECAY;
          end else begin
            env_d = attack_sum[WIDTH-1:0];
          end
        end
        S_DECAY: begin
          if (decay_done) begin
            env_d   = sustain_level;
            state_d = S_SUSTAIN;
          end else begin
            env_d = env_q - decay_rate;
          end
        end
        S_SUSTAIN: begin
          env_d = sustain_level;
        end
        S_RELEASE: begin
          if (release_done) begin
            env_d   = '0;
            state_d = S_IDLE;
          end else begin
            env_d = env_q - release_rate;
          end
        end
        default: begin
          env_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      env_q     <= '0;
      active_q  <= 1'b0;
      pre_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      env_q     <= env_d;
      active_q  <= active_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign env_out   = env_q;
  assign state_out = state_q;
  assign active    = active_q;

endmodule

// File: doc/adsr_env.md
Name: adsr_env

Overview:
- ADSR envelope generator producing the control-voltage word for the voltage-controlled amplifier (VCA) cv input.
- Sits directly upstream of the VCA, in place of the free-running triangle LFO used as cv today.
- A gate input drives a five-state machine: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Per-stage rates and the sustain level are runtime inputs. A prescaler sets the envelope update tick.

Parameters:
- WIDTH, 32: envelope word width. MAX = 2^WIDTH-1.
- PRESCALE, 1: clocks per envelope tick. Must be ≥1; 1 means every clock.
- PRE_W, 16: prescaler counter width. Must satisfy PRESCALE ≤ 2^PRE_W.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- gate, in, 1: note-on level (1 = key held).
- attack_rate, in, WIDTH: amount added per tick in ATTACK.
- decay_rate, in, WIDTH: amount subtracted per tick in DECAY.
- sustain_level, in, WIDTH: level held in SUSTAIN.
- release_rate, in, WIDTH: amount subtracted per tick in RELEASE.
- env_out, out, WIDTH: registered envelope value; connects to the VCA cv (top bits for the 8-bit VCAs).
- state_out, out, 3: encoding IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- active, out, 1: registered; 1 whenever state_out != IDLE.

Behaviour:
Reset and clocking:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset (at any time, including mid-envelope) sets env_out=0, state=IDLE, active=0, prescaler=0 on that edge.

Prescaler and tick:
- Counts 0..PRESCALE-1 and wraps. tick=1 on clocks where count==PRESCALE-1.
- Envelope arithmetic happens only on tick edges.

Gate-driven transitions:
- Taken on any edge, independent of tick.
- On such an edge env_out holds its value; arithmetic resumes on the next tick.
- IDLE or RELEASE with gate=1 → ATTACK. This is a retrigger from the current env_out, not from 0.
- ATTACK, DECAY or SUSTAIN with gate=0 → RELEASE.
- A gate transition takes priority over a tick on the same edge.

Per-stage arithmetic (on tick, no gate transition pending):
- ATTACK: sum = env_out + attack_rate, computed at WIDTH+1 bits. If sum ≥ MAX, env_out=MAX and state→DECAY on the same edge; otherwise env_out=sum.
- DECAY: if env_out - decay_rate ≤ sustain_level (borrow-safe compare), env_out=sustain_level and state→SUSTAIN on the same edge; otherwise subtract.
- SUSTAIN: env_out=sustain_level on every tick. The envelope follows live changes to sustain_level.
- RELEASE: if env_out ≤ release_rate, env_out=0 and state→IDLE on the same edge; otherwise subtract.
- IDLE: env_out holds at 0.

Boundary cases:
- A rate of 0 holds the current stage indefinitely (gate transitions still apply).
- sustain_level=MAX: DECAY exits to SUSTAIN on its first tick.
- sustain_level=0: the envelope decays to 0 and holds there in SUSTAIN.
- No wrap-around is ever allowed: all adds saturate and all subtracts floor.

Output timing:
- state_out and env_out update on the same edge.
- active is derived from the next-state value, so it changes on the same edge as state_out.
- Latency: gate sampled high at edge k gives state_out=ATTACK after edge k; the first increment is visible after the first tick edge following k.

Test Plan:
Bench configuration: WIDTH=8, PRESCALE=1 unless noted.

1. Full ADSR cycle: attack=64, decay=16, sustain=200, release=50; gate rises at edge k, then drops once SUSTAIN is reached.
   - Edge k: ATTACK, env 0.
   - Next edges: env 64, 128, 192, 255 (DECAY entered on the 255 edge).
   - Then: 239, 223, 207, 200 (SUSTAIN on the 200 edge).
   - On gate drop: RELEASE, env holds 200.
   - Then: 150, 100, 50, 0, with IDLE and active=0 on the 0 edge.
2. Early release: gate drops while env=128 in ATTACK.
   - Edge: RELEASE, env 128. Then 78, 28, 0 → IDLE.
3. Retrigger: gate re-asserted during RELEASE at env=100.
   - Edge: ATTACK, env 100. Then 164, 228, 255 → DECAY.
4. Prescaler: PRESCALE=4, attack=64.
   - env steps every 4th clock: 64 after clock 4, 128 after clock 8.
   - Verify env holds on non-tick clocks.
5. Reset and edge rates:
   - Assert reset in DECAY at env=223: next edge env 0, IDLE, active 0.
   - attack=0 with gate=1 holds ATTACK at 0 for 20 clocks.
   - sustain=255: DECAY → SUSTAIN on its first tick at 255.
6. Live sustain: in SUSTAIN at 200, change sustain_level to 180.
   - env_out reads 180 after the next tick; state stays SUSTAIN.
